// File: rtl/nibble_denormalizer.sv
// Iterative right-shifter: nibble steps in COARSE, then one 0..3-bit step in FINE.
// Define DENORMALIZER_STICKY_EN to build the lost-bit (sticky) accumulator.
module nibble_denormalizer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_WIDTH-1:0]         operand_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] shift_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [DATA_WIDTH-1:0]         result_o,
  output logic                          sticky_o,
  output logic                          valid_o
);

  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COARSE = 2'd1;
  localparam logic [1:0] S_FINE   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [SW-3:0] NIB_ONE = 1;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 24) begin : g_bad_width
    $error("nibble_denormalizer: DATA_WIDTH must be 32 or 24");
  end

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SW-3:0]         nib_q, nib_d;
  logic [1:0]            fine_q, fine_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  valid_q, valid_d;

`ifdef DENORMALIZER_STICKY_EN
  logic       sticky_q, sticky_d;
  logic       sticky_res_q, sticky_res_d;
  logic [3:0] fine_mask;

  always_comb begin
    fine_mask = 4'b0000;
    case (fine_q)
      2'd1:    fine_mask = 4'b0001;
      2'd2:    fine_mask = 4'b0011;
      2'd3:    fine_mask = 4'b0111;
      default: fine_mask = 4'b0000;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    nib_d    = nib_q;
    fine_d   = fine_q;
    result_d = result_q;
    valid_d  = 1'b0;
`ifdef DENORMALIZER_STICKY_EN
    sticky_d     = sticky_q;
    sticky_res_d = sticky_res_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          data_d  = operand_i;
          nib_d   = shift_i[SW-1:2];
          fine_d  = shift_i[1:0];
`ifdef DENORMALIZER_STICKY_EN
          sticky_d = 1'b0;
`endif
          state_d = (shift_i[SW-1:2] != '0) ? S_COARSE : S_FINE;
        end
      end
      S_COARSE: begin
        data_d = data_q >> 4;
        nib_d  = nib_q - NIB_ONE;
`ifdef DENORMALIZER_STICKY_EN
        sticky_d = sticky_q | (|data_q[3:0]);
`endif
        if (nib_q == NIB_ONE) state_d = S_FINE;
      end
      S_FINE: begin
        // The fine step writes straight into the output register, so DONE only pulses valid.
        data_d   = data_q >> fine_q;
        result_d = data_q >> fine_q;
`ifdef DENORMALIZER_STICKY_EN
        sticky_d     = sticky_q | (|(data_q[3:0] & fine_mask));
        sticky_res_d = sticky_q | (|(data_q[3:0] & fine_mask));
`endif
        state_d = S_DONE;
      end
      default: begin
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      nib_q    <= '0;
      fine_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      nib_q    <= nib_d;
      fine_q   <= fine_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

`ifdef DENORMALIZER_STICKY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_q     <= 1'b0;
      sticky_res_q <= 1'b0;
    end else begin
      sticky_q     <= sticky_d;
      sticky_res_q <= sticky_res_d;
    end
  end

  assign sticky_o = sticky_res_q;
`else
  assign sticky_o = 1'b0;
`endif

  assign ready_o  = (state_q == S_IDLE);
  assign result_o = result_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_nibble_denormalizer.sv
// Scoreboarded bench for nibble_denormalizer at DATA_WIDTH 32 and 24.
module tb_nibble_denormalizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] op32 = '0;
  logic [4:0]  sh32 = '0;
  logic        vi32 = 1'b0;
  logic        rdy32, st32, vo32;
  logic [31:0] r32;

  logic [23:0] op24 = '0;
  logic [4:0]  sh24 = '0;
  logic        vi24 = 1'b0;
  logic        rdy24, st24, vo24;
  logic [23:0] r24;

  nibble_denormalizer #(.DATA_WIDTH(32)) u32 (
    .clk_i(clk), .rst_i(rst), .operand_i(op32), .shift_i(sh32), .valid_i(vi32),
    .ready_o(rdy32), .result_o(r32), .sticky_o(st32), .valid_o(vo32));

  nibble_denormalizer #(.DATA_WIDTH(24)) u24 (
    .clk_i(clk), .rst_i(rst), .operand_i(op24), .shift_i(sh24), .valid_i(vi24),
    .ready_o(rdy24), .result_o(r24), .sticky_o(st24), .valid_o(vo24));

  typedef struct {
    logic [31:0] res;
    logic        sticky;
    int unsigned lat;
    int unsigned acc;
    logic [4:0]  shift;
    logic        msb;
  } exp_t;

  exp_t q32[$];
  exp_t q24[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] op, input logic [4:0] sh,
                              input int unsigned w, input int unsigned acc);
    exp_t e;
    logic [63:0] full;
    logic [63:0] mask;
    full     = {32'b0, op} & ((64'd1 << w) - 64'd1);
    mask     = (64'd1 << sh) - 64'd1;
    e.res    = 32'(full >> sh);
`ifdef DENORMALIZER_STICKY_EN
    e.sticky = |(full & mask);
`else
    e.sticky = 1'b0;
`endif
    e.lat    = 32'(sh >> 2) + 2;
    e.acc    = acc;
    e.shift  = sh;
    e.msb    = full[w-1];
    return e;
  endfunction

  function automatic int unsigned clz(input logic [31:0] v, input int unsigned w);
    int unsigned n = 0;
    bit found = 1'b0;
    for (int i = int'(w) - 1; i >= 0; i--) begin
      if (v[i]) found = 1'b1;
      else if (!found) n++;
    end
    return n;
  endfunction

  task automatic check_out(input string tag, input exp_t e, input logic [31:0] res,
                           input logic st, input logic rdy, input int unsigned w);
    chk({tag, "_result"}, res, e.res);
    chk({tag, "_sticky"}, 32'(st), 32'(e.sticky));
    chk({tag, "_latency"}, cyc - e.acc, e.lat);
    chk({tag, "_ready_after_done"}, 32'(rdy), 32'd1);
    if (e.msb && e.shift < w) chk({tag, "_clz"}, clz(res, w), 32'(e.shift));
  endtask

  always @(negedge clk) begin
    if (!rst && vo32 === 1'b1) begin
      checks++;
      assert (q32.size() != 0) else begin
        errors++;
        $error("FAIL spurious_valid32 observed=1 expected=0");
      end
      if (q32.size() != 0) check_out("w32", q32.pop_front(), r32, st32, rdy32, 32);
    end
    if (!rst && vo24 === 1'b1) begin
      checks++;
      assert (q24.size() != 0) else begin
        errors++;
        $error("FAIL spurious_valid24 observed=1 expected=0");
      end
      if (q24.size() != 0) check_out("w24", q24.pop_front(), {8'b0, r24}, st24, rdy24, 24);
    end
  end

  task automatic send32(input logic [31:0] op, input logic [4:0] sh);
    @(negedge clk);
    chk("ready32_before_accept", 32'(rdy32), 32'd1);
    op32 = op; sh32 = sh; vi32 = 1'b1;
    @(posedge clk); #1;
    q32.push_back(mk(op, sh, 32, cyc));
    vi32 = 1'b0;
  endtask

  task automatic send24(input logic [23:0] op, input logic [4:0] sh);
    @(negedge clk);
    chk("ready24_before_accept", 32'(rdy24), 32'd1);
    op24 = op; sh24 = sh; vi24 = 1'b1;
    @(posedge clk); #1;
    q24.push_back(mk({8'b0, op}, sh, 24, cyc));
    vi24 = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (q32.size() != 0 || q24.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_drain_pending"}, q32.size() + q24.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_result32", r32, 32'h0);
    chk("reset_sticky32", 32'(st32), 32'd0);
    chk("reset_valid32", 32'(vo32), 32'd0);
    chk("reset_ready32", 32'(rdy32), 32'd1);
    chk("reset_ready24", 32'(rdy24), 32'd1);
    rst = 1'b0;

    send32(32'h8000_0001, 5'd0);  drain("s0");
    send32(32'hF000_0011, 5'd5);  drain("s5");
    send32(32'h8000_0000, 5'd31); drain("s31");
    send32(32'h0000_0000, 5'd17); drain("zero");
    send32(32'hFFFF_FFFF, 5'd3);  drain("ones3");
    send32(32'h1234_5678, 5'd12); drain("s12");
    send32(32'h8765_4321, 5'd16); drain("s16");
    for (int i = 0; i < 4; i++) begin
      send32($urandom | 32'h8000_0000, 5'($urandom_range(0, 31)));
      drain("rand32");
    end

    send24(24'hFFFFFF, 5'd27); drain("w24_s27");
    send24(24'h800000, 5'd23); drain("w24_s23");
    send24(24'hABCDEF, 5'd4);  drain("w24_s4");
    send24(24'h000000, 5'd9);  drain("w24_zero");
    send24(24'hC00001, 5'd24); drain("w24_s24");

    // Request arriving while busy must be dropped.
    send32(32'hDEAD_BEEF, 5'd8);
    @(negedge clk);
    chk("busy_ready32", 32'(rdy32), 32'd0);
    op32 = 32'h1111_1111; sh32 = 5'd0; vi32 = 1'b1;
    @(negedge clk);
    vi32 = 1'b0;
    drain("busy");
    repeat (6) @(negedge clk);

    // Reset in COARSE discards the request.
    send32(32'hFFFF_0000, 5'd20);
    @(negedge clk); @(negedge clk);
    chk("pre_reset_ready32", 32'(rdy32), 32'd0);
    #2 rst = 1'b1;
    #1;
    void'(q32.pop_back());
    chk("midreset_result32", r32, 32'h0);
    chk("midreset_sticky32", 32'(st32), 32'd0);
    chk("midreset_valid32", 32'(vo32), 32'd0);
    chk("midreset_ready32", 32'(rdy32), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    send32(32'hFFFF_0000, 5'd20); drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
